// File: rtl/lift_position_ctrl_pkg.sv
// Shared floor-bus encodings, controller state codes and direction helpers
// for the lift position controller and its display consumer.
package lift_position_ctrl_pkg;

  localparam int NUM_FLOORS = 4;

  localparam logic [NUM_FLOORS-1:0] FLOOR_IDLE = 4'b0000;
  localparam logic [NUM_FLOORS-1:0] FLOOR1     = 4'b0001;
  localparam logic [NUM_FLOORS-1:0] FLOOR2     = 4'b0010;
  localparam logic [NUM_FLOORS-1:0] FLOOR3     = 4'b0100;
  localparam logic [NUM_FLOORS-1:0] FLOOR4     = 4'b1000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MOVE = 2'd1;
  localparam logic [1:0] ST_DOOR = 2'd2;

  // Floors strictly above (up=1) or strictly below (up=0) a one-hot position.
  function automatic logic [NUM_FLOORS-1:0] dir_mask(input logic [NUM_FLOORS-1:0] p,
                                                     input logic up);
    logic [NUM_FLOORS-1:0] below;
    below = p - 4'd1;
    return up ? ~(p | below) : below;
  endfunction

endpackage

// File: rtl/lift_interval_timer.sv
// Interval counter shared by travel and door phases; clear wins over count,
// and tc flags the count sitting on the supplied terminal value.
module lift_interval_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == term);

endmodule

// File: rtl/lift_position_ctrl.sv
// Lift-car position controller: latches floor calls, schedules SCAN travel
// one floor per interval, holds the door at served floors, drives one-hot pos.
module lift_position_ctrl
  import lift_position_ctrl_pkg::*;
#(
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [NUM_FLOORS-1:0] pos,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  moving,
  output logic                  dir_up,
  output logic                  door_open
);

  logic [1:0]            state_q, state_d;
  logic [NUM_FLOORS-1:0] pos_q, pos_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  dir_up_q, dir_up_d;
  logic                  moving_q, moving_d;
  logic                  door_open_q, door_open_d;

  logic [NUM_FLOORS-1:0] all_req;
  logic [NUM_FLOORS-1:0] next_pos;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic                  eff_dir;
  logic                  door_restart;
  logic                  timer_clear;
  logic                  timer_en;
  logic                  tc;
  logic [CNT_W-1:0]      term;

  always_comb begin
    all_req      = pending_q | req;
    eff_dir      = (pos_q == FLOOR4) ? 1'b0 : (pos_q == FLOOR1) ? 1'b1 : dir_up_q;
    next_pos     = dir_up_q ? ((pos_q == FLOOR4) ? pos_q : pos_q << 1)
                            : ((pos_q == FLOOR1) ? pos_q : pos_q >> 1);
    door_restart = (state_q == ST_DOOR) && (|(req & pos_q));

    state_d  = state_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;

    case (state_q)
      ST_IDLE: begin
        dir_up_d = eff_dir;
        if (|(all_req & pos_q)) begin
          state_d = ST_DOOR;
        end else if (|(all_req & dir_mask(pos_q, eff_dir))) begin
          state_d = ST_MOVE;
        end else if (|(all_req & dir_mask(pos_q, !eff_dir))) begin
          dir_up_d = !eff_dir;
          state_d  = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (tc) begin
          pos_d = next_pos;
          if (|(all_req & next_pos)) begin
            state_d = ST_DOOR;
          end else if (|(all_req & dir_mask(next_pos, dir_up_q))) begin
            state_d = ST_MOVE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        if (tc && !door_restart) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The served floor is cleared on the entry cycle and throughout the stop.
    clear_mask  = ((state_q == ST_DOOR) || (state_d == ST_DOOR)) ? pos_d : FLOOR_IDLE;
    pending_d   = all_req & ~clear_mask;
    moving_d    = (state_d == ST_MOVE);
    door_open_d = (state_d == ST_DOOR);

    timer_clear = (state_q == ST_IDLE) || (state_d != state_q) || tc || door_restart;
    timer_en    = (state_q != ST_IDLE);
    term        = (state_q == ST_MOVE) ? CNT_W'(TRAVEL_CYCLES - 1) : CNT_W'(DOOR_CYCLES - 1);
  end

  lift_interval_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_en),
    .term   (term),
    .tc     (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pos_q       <= FLOOR1;
      pending_q   <= FLOOR_IDLE;
      dir_up_q    <= 1'b1;
      moving_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      pending_q   <= pending_d;
      dir_up_q    <= dir_up_d;
      moving_q    <= moving_d;
      door_open_q <= door_open_d;
    end
  end

  assign pos       = pos_q;
  assign pending   = pending_q;
  assign moving    = moving_q;
  assign dir_up    = dir_up_q;
  assign door_open = door_open_q;

endmodule

// File: tb/tb_lift_position_ctrl.sv
// Directed self-checking bench for lift_position_ctrl with hand-computed
// expectations, per-cycle invariant checks and a bounded random soak.
module tb_lift_position_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] pos;
  logic [3:0] pending;
  logic       moving;
  logic       dir_up;
  logic       door_open;

  int checks;
  int errors;

  lift_position_ctrl #(
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3),
    .CNT_W         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .pos       (pos),
    .pending   (pending),
    .moving    (moving),
    .dir_up    (dir_up),
    .door_open (door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkInvariants();
    checks++;
    assert ($onehot(pos) && !(moving && door_open)) else begin
      errors++;
      $error("[TB] FAIL invariant observed pos=%b moving=%b door_open=%b required one-hot pos and not both",
             pos, moving, door_open);
    end
  endtask

  // Hold req for n rising edges, sampling 1 time unit after each edge.
  task automatic applyStimulus(input logic [3:0] r, input int n);
    req = r;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checkInvariants();
    end
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] e_pos,
                             input logic [3:0] e_pending, input logic e_moving,
                             input logic e_dir, input logic e_door);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {pos, pending, moving, dir_up, door_open};
    exp = {e_pos, e_pending, e_moving, e_dir, e_door};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed pos=%b pend=%b mv=%b up=%b door=%b required pos=%b pend=%b mv=%b up=%b door=%b",
             tag, obs[10:7], obs[6:3], obs[2], obs[1], obs[0],
             exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    logic done;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;

    // Call at the current floor: door opens next cycle, no movement.
    applyStimulus(4'b0001, 1);
    checkOutput("here_door0", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("here_door1", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("here_door2", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("here_close", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);

    // One-cycle call to FLOOR3 from FLOOR1.
    applyStimulus(4'b0100, 1);
    checkOutput("f3_start", 4'b0001, 4'b0100, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 3);
    checkOutput("f3_still_f1", 4'b0001, 4'b0100, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("f3_at_f2", 4'b0010, 4'b0100, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4);
    checkOutput("f3_arrive", 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 2);
    checkOutput("f3_door_last", 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("f3_idle", 4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0);

    // From FLOOR3 going up with calls at 4 and 1: serve 4, reverse, sweep to 1.
    applyStimulus(4'b1001, 1);
    checkOutput("sweep_start", 4'b0100, 4'b1001, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4);
    checkOutput("sweep_f4_door", 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 3);
    checkOutput("sweep_f4_idle", 4'b1000, 4'b0001, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("sweep_reverse", 4'b1000, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4);
    checkOutput("sweep_pass_f3", 4'b0100, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4);
    checkOutput("sweep_pass_f2", 4'b0010, 4'b0001, 1'b1, 1'b0, 1'b0);
    applyStimulus(4'b0000, 4);
    checkOutput("sweep_f1_door", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 3);
    checkOutput("sweep_f1_idle", 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1);
    checkOutput("f1_dir_forced", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Door at FLOOR2 held open by repeated calls for the same floor.
    applyStimulus(4'b0010, 1);
    checkOutput("hold_start", 4'b0001, 4'b0010, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 4);
    checkOutput("hold_door", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0010, 1);
    checkOutput("hold_req1", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1);
    applyStimulus(4'b0010, 1);
    checkOutput("hold_req2", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 2);
    checkOutput("hold_still_open", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b1);
    applyStimulus(4'b0000, 1);
    checkOutput("hold_close", 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Calls above and below: current (up) direction wins; then async reset mid-move.
    applyStimulus(4'b1001, 1);
    checkOutput("tie_up_wins", 4'b0010, 4'b1001, 1'b1, 1'b1, 1'b0);
    applyStimulus(4'b0000, 2);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'b0000, 1);
    checkOutput("post_reset_idle", 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0);

    // Sparse random calls, then drain: everything must be served.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        applyStimulus(4'($urandom_range(0, 15)), 1);
      end else begin
        applyStimulus(4'b0000, 1);
      end
    end
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      applyStimulus(4'b0000, 1);
      done = (pending == 4'b0000) && !moving && !door_open;
    end
    checks++;
    assert (done === 1'b1) else begin
      errors++;
      $error("[TB] FAIL drain observed pending=%b moving=%b door=%b required all served and idle",
             pending, moving, door_open);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
